wb_arbiter: RTL

Write-back arbiter for the pico-MIPS register file's single write port. Two write-back sources (A: ALU path, B: multi-cycle unit path) each present a valid/ready write request. The block grants them round-robin, registers the winner into a one-entry output stage that drives the register file's write port, and provides a combinational forwarding lookup for the write in flight. A saturating conflict counter supports performance debug.

---
 rtl/wb_arbiter_if.sv | 48 ++++
 rtl/wb_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the write-back arbiter, its two requesters, the
// register-file write port and the datapath forwarding lookup.
interface wb_arbiter_if #(
   parameter int M = 32,
   parameter int N = 8
);
   localparam int ADDR_SZ = $clog2(M);

   logic               a_valid;
   logic               a_ready;
   logic [ADDR_SZ-1:0] a_addr;
   logic [N-1:0]       a_data;

   logic               b_valid;
   logic               b_ready;
   logic [ADDR_SZ-1:0] b_addr;
   logic [N-1:0]       b_data;

   logic               w_enable;
   logic [ADDR_SZ-1:0] w_addr;
   logic [N-1:0]       w_data;

   logic [ADDR_SZ-1:0] q_addr;
   logic               q_hit;
   logic [N-1:0]       q_data;

   logic [7:0]         conflict_cnt;

   modport slave (
      input  a_valid, a_addr, a_data,
      input  b_valid, b_addr, b_data,
      input  q_addr,
      output a_ready, b_ready,
      output w_enable, w_addr, w_data,
      output q_hit, q_data,
      output conflict_cnt
   );

   modport master (
      output a_valid, a_addr, a_data,
      output b_valid, b_addr, b_data,
      output q_addr,
      input  a_ready, b_ready,
      input  w_enable, w_addr, w_data,
      input  q_hit, q_data,
      input  conflict_cnt
   );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a
// one-entry registered write stage and a forwarding lookup on that stage.
//
// state   | meaning
// GRANT_A | A won the most recent transfer; B wins the next conflict
// GRANT_B | B won the most recent transfer (or reset); A wins the next conflict
module wb_arbiter #(
   parameter int M = 32,
   parameter int N = 8
) (
   input logic        clk,
   input logic        rst,
   wb_arbiter_if.slave bus
);
   localparam int ADDR_SZ = $clog2(M);

   typedef enum logic {
      GRANT_A = 1'b0,
      GRANT_B = 1'b1
   } grant_t;

   grant_t             last_grant;
   grant_t             last_grant_nxt;
   logic               a_rdy;
   logic               b_rdy;
   logic               a_xfer;
   logic               b_xfer;
   logic               w_enable_q;
   logic [ADDR_SZ-1:0] w_addr_q;
   logic [N-1:0]       w_data_q;
   logic [7:0]         cnt_q;

   always_ff @(posedge clk) begin
      if (rst) last_grant <= GRANT_B;
      else     last_grant <= last_grant_nxt;
   end

   always_comb begin
      a_rdy          = 1'b0;
      b_rdy          = 1'b0;
      last_grant_nxt = last_grant;
      if (!rst) begin
         if (bus.a_valid && bus.b_valid) begin
            if (last_grant == GRANT_B) a_rdy = 1'b1;
            else                       b_rdy = 1'b1;
         end else begin
            a_rdy = bus.a_valid;
            b_rdy = bus.b_valid;
         end
      end
      if (bus.a_valid && a_rdy)      last_grant_nxt = GRANT_A;
      else if (bus.b_valid && b_rdy) last_grant_nxt = GRANT_B;
   end

   assign a_xfer = bus.a_valid && a_rdy;
   assign b_xfer = bus.b_valid && b_rdy;

   // Writes to register 0 are accepted but never enabled on the write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_enable_q <= 1'b0;
         w_addr_q   <= '0;
         w_data_q   <= '0;
         cnt_q      <= '0;
      end else begin
         if (a_xfer) begin
            w_enable_q <= (bus.a_addr != '0);
            w_addr_q   <= bus.a_addr;
            w_data_q   <= bus.a_data;
         end else if (b_xfer) begin
            w_enable_q <= (bus.b_addr != '0);
            w_addr_q   <= bus.b_addr;
            w_data_q   <= bus.b_data;
         end else begin
            w_enable_q <= 1'b0;
         end
         if (bus.a_valid && bus.b_valid && (cnt_q != 8'hFF)) cnt_q <= cnt_q + 8'd1;
      end
   end

   assign bus.a_ready      = a_rdy;
   assign bus.b_ready      = b_rdy;
   assign bus.w_enable     = w_enable_q;
   assign bus.w_addr       = w_addr_q;
   assign bus.w_data       = w_data_q;
   assign bus.q_hit        = !rst && w_enable_q && (w_addr_q == bus.q_addr) && (bus.q_addr != '0);
   assign bus.q_data       = w_data_q;
   assign bus.conflict_cnt = cnt_q;

   a_hold: assert property (@(posedge clk) disable iff (rst)
      bus.a_valid && !a_rdy |=> bus.a_valid && $stable(bus.a_addr) && $stable(bus.a_data));
   b_hold: assert property (@(posedge clk) disable iff (rst)
      bus.b_valid && !b_rdy |=> bus.b_valid && $stable(bus.b_addr) && $stable(bus.b_data));
endmodule
